// File: rtl/qea_pkg.sv
// qea_pkg: shared state encoding and state-row count helper for the QEA host sequencer.
package qea_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_CTX,
        S_LOAD_ST,
        S_START,
        S_RUN,
        S_READ,
        S_DONE,
        S_ERR
    } seq_state_t;

    // A state row carries 2**pe_num_width amplitudes, so small registers still need one row.
    function automatic logic [31:0] qea_rows(input int qbit_num, input int pe_num_width);
        if (qbit_num >= pe_num_width) return 32'd1 << (qbit_num - pe_num_width);
        return 32'd1;
    endfunction

endpackage

// File: rtl/qea_rd_skid.sv
// qea_rd_skid: state RAM read-latency pipe plus a one-entry hold register for the result stream.
module qea_rd_skid #(
    parameter int DATA_W = 256,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [DATA_W-1:0] rd_dout,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              idle
);

    logic [RD_LAT-1:0] vld_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            // latency pipe: RAM output is valid when the tag reaches the last stage
            vld_p[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
            // hold stage
            if (vld_p[RD_LAT-1]) begin
                rd_valid <= 1'b1;
                rd_data  <= rd_dout;
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

    assign idle = ~(|vld_p) & ~rd_valid;

endmodule

// File: rtl/qea_host_sequencer.sv
// qea_host_sequencer: loads gate context and state rows, runs the QEA core, streams rows back.
// Optional RUN watchdog enabled by defining QEA_SEQ_TIMEOUT_EN.
module qea_host_sequencer
    import qea_pkg::*;
#(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int RD_LAT                  = 1,
    parameter int CYC_W                   = 32,
    parameter int TIMEOUT_CYCLES          = 2**20
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_err,
    output logic [CYC_W-1:0]                     o_cycles,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    input  logic                                 i_st_valid,
    output logic                                 o_st_ready,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_st_data,
    output logic                                 o_rd_valid,
    input  logic                                 i_rd_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic [PE_NUM-1:0]                    o_state_ena,
    output logic [PE_NUM-1:0]                    o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    output logic                                 o_qea_start,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout
);

    localparam int SW = PE_NUM * STATE_DATA_WIDTH;
    localparam logic [GATE_CONTEXT_ADDR_WIDTH:0] INS_ONE = 1;
    localparam logic [STATE_ADDR_WIDTH-1:0]      ROW_ONE = 1;
    localparam logic [CYC_W-1:0]                 CYC_ONE = 1;

    seq_state_t state;
    logic busy_q, done_q, start_q, ctx_ready_q, st_ready_q;
    logic [CYC_W-1:0] cycles_q;
    logic [GATE_CONTEXT_ADDR_WIDTH:0] ctx_cnt, ins_last;
    logic [STATE_ADDR_WIDTH-1:0] st_row, rd_row, last_row;
    logic ctx_beat, st_beat, rd_issue, rd_idle, rd_acc, rd_valid;

    function automatic logic [CYC_W-1:0] cyc_sat_inc(input logic [CYC_W-1:0] v);
        return (v == '1) ? v : v + CYC_ONE;
    endfunction

`ifdef QEA_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_ONE  = 1;
    logic [TO_W-1:0] run_cnt;
    logic err_q;
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            ctx_ready_q <= 1'b0;
            st_ready_q  <= 1'b0;
            cycles_q    <= '0;
`ifdef QEA_SEQ_TIMEOUT_EN
            err_q       <= 1'b0;
            run_cnt     <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            start_q <= 1'b0;
            unique case (state)
                S_IDLE: if (i_go) begin
                    ins_last <= i_ins_num - INS_ONE;
                    last_row <= STATE_ADDR_WIDTH'(qea_rows(int'(i_qbit_num), PE_NUM_WIDTH) - 32'd1);
                    cycles_q <= '0;
                    ctx_cnt  <= '0;
                    st_row   <= '0;
                    rd_row   <= '0;
                    busy_q   <= 1'b1;
                    if (i_ins_num == '0) begin
                        state      <= S_LOAD_ST;
                        st_ready_q <= 1'b1;
                    end else begin
                        state       <= S_LOAD_CTX;
                        ctx_ready_q <= 1'b1;
                    end
                end
                S_LOAD_CTX: if (ctx_beat) begin
                    ctx_cnt <= ctx_cnt + INS_ONE;
                    if (ctx_cnt == ins_last) begin
                        ctx_ready_q <= 1'b0;
                        st_ready_q  <= 1'b1;
                        state       <= S_LOAD_ST;
                    end
                end
                S_LOAD_ST: if (st_beat) begin
                    st_row <= st_row + ROW_ONE;
                    if (st_row == last_row) begin
                        st_ready_q <= 1'b0;
                        start_q    <= 1'b1;
                        cycles_q   <= CYC_ONE;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (i_qea_complete) begin
                        state <= S_READ;
                    end else begin
                        cycles_q <= cyc_sat_inc(cycles_q);
                        state    <= S_RUN;
                    end
`ifdef QEA_SEQ_TIMEOUT_EN
                    run_cnt <= TO_ONE;
`endif
                end
                S_RUN: if (i_qea_complete) begin
                    state <= S_READ;
                end else begin
                    cycles_q <= cyc_sat_inc(cycles_q);
`ifdef QEA_SEQ_TIMEOUT_EN
                    if (run_cnt == TO_LAST) begin
                        state  <= S_ERR;
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + TO_ONE;
                    end
`endif
                end
                S_READ: if (rd_acc) begin
                    rd_row <= rd_row + ROW_ONE;
                    if (rd_row == last_row) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                S_ERR: if (i_go) begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
`ifdef QEA_SEQ_TIMEOUT_EN
                    err_q  <= 1'b0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stream writes go straight to the core RAMs in the accepting cycle for zero-bubble loads.
    assign ctx_beat = ctx_ready_q & i_ctx_valid;
    assign st_beat  = st_ready_q & i_st_valid;
    assign rd_issue = (state == S_READ) & rd_idle;
    assign rd_acc   = rd_valid & i_rd_ready;

    assign o_ctx_ready   = ctx_ready_q;
    assign o_st_ready    = st_ready_q;
    assign o_ctx_en      = ctx_beat;
    assign o_ctx_wea     = ctx_beat;
    assign o_ctx_addr    = ctx_ready_q ? ctx_cnt[GATE_CONTEXT_ADDR_WIDTH-1:0] : '0;
    assign o_ctx_data    = ctx_ready_q ? i_ctx_data : '0;
    assign o_state_ena   = {PE_NUM{st_beat | rd_issue}};
    assign o_state_wea   = {PE_NUM{st_beat}};
    assign o_state_addra = st_ready_q ? st_row : (rd_issue ? rd_row : '0);
    assign o_state_dina  = st_ready_q ? i_st_data : '0;
    assign o_qea_start   = start_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_cycles      = cycles_q;
    assign o_rd_valid    = rd_valid;

    qea_rd_skid #(
        .DATA_W (SW),
        .RD_LAT (RD_LAT)
    ) u_rd_skid (
        .clk      (clk),
        .rst      (rst),
        .issue    (rd_issue),
        .rd_dout  (i_qea_state_dout),
        .rd_ready (i_rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (o_rd_data),
        .idle     (rd_idle)
    );

endmodule

// File: doc/qea_host_sequencer.md
QEA_HOST_SEQUENCER -- requirements
Module: qea_host_sequencer

Interface
REQ-001 SHALL have parameters: PE_NUM_WIDTH, default 2, log2 of the PE count; PE_NUM, default 4, PEs per state row; STATE_DATA_WIDTH, default 64, one complex amplitude; STATE_ADDR_WIDTH, default 16; GATE_CONTEXT_DATA_WIDTH, default 64; GATE_CONTEXT_ADDR_WIDTH, default 16; MAX_QBIT_WIDTH, default 6; RD_LAT, default 1, state RAM read latency in cycles; CYC_W, default 32, cycle-counter width; TIMEOUT_CYCLES, default 2**20.
REQ-002 SHALL use one clock; reset is synchronous and active-high. Ports: clk in 1, clock; rst in 1, reset.
REQ-003 SHALL have host ports: i_go in 1, start a job; i_qbit_num in MAX_QBIT_WIDTH, qubit count; i_ins_num in GATE_CONTEXT_ADDR_WIDTH+1, context word count; o_busy out 1, job in progress; o_done out 1, one-cycle pulse at job end; o_err out 1, sticky timeout flag; o_cycles out CYC_W, execution cycle count.
REQ-004 SHALL have stream ports: i_ctx_valid in 1; o_ctx_ready out 1; i_ctx_data in GATE_CONTEXT_DATA_WIDTH; i_st_valid in 1; o_st_ready out 1; i_st_data in PE_NUM*STATE_DATA_WIDTH; o_rd_valid out 1; i_rd_ready in 1; o_rd_data out PE_NUM*STATE_DATA_WIDTH.
REQ-005 SHALL have core-side ports: o_ctx_en, o_ctx_wea out 1; o_ctx_addr out GATE_CONTEXT_ADDR_WIDTH; o_ctx_data out GATE_CONTEXT_DATA_WIDTH; o_state_ena, o_state_wea out PE_NUM each; o_state_addra out STATE_ADDR_WIDTH; o_state_dina out PE_NUM*STATE_DATA_WIDTH; o_qea_start out 1; i_qea_complete in 1; i_qea_state_dout in PE_NUM*STATE_DATA_WIDTH.

Function
REQ-006 SHALL implement states IDLE, LOAD_CTX, LOAD_ST, START, RUN, READ, DONE, ERR.
REQ-007 SHALL, in IDLE with i_go=1, latch i_qbit_num and i_ins_num, clear o_cycles, and go to LOAD_CTX, or to LOAD_ST if i_ins_num=0; i_go SHALL be ignored in every other state.
REQ-008 SHALL compute ROWS = 2**(qbit_num-PE_NUM_WIDTH) when qbit_num >= PE_NUM_WIDTH, else ROWS=1.
REQ-009 LOAD_CTX: o_ctx_ready=1; each i_ctx_valid&o_ctx_ready beat SHALL drive o_ctx_en=o_ctx_wea=1 with addresses 0..ins_num-1, one per cycle; zero-bubble throughput; after the last beat go to LOAD_ST.
REQ-010 LOAD_ST: o_st_ready=1; each accepted beat SHALL drive o_state_ena=o_state_wea=all ones with addresses 0..ROWS-1; after the last beat go to START.
REQ-011 START SHALL pulse o_qea_start for exactly one cycle, then go to RUN.
REQ-012 o_cycles SHALL count from the o_qea_start cycle (value 1) through the first cycle with i_qea_complete=1 inclusive, saturating at all ones; on complete go to READ.
REQ-013 READ SHALL, per row 0..ROWS-1, issue one read (o_state_ena=all ones, o_state_wea=0), capture i_qea_state_dout RD_LAT cycles later into o_rd_data, and hold o_rd_valid until i_rd_ready; the next read SHALL issue only after acceptance.
REQ-014 After the last accepted row, DONE SHALL pulse o_done for one cycle and return to IDLE.
REQ-015 o_busy SHALL be 1 in every state except IDLE; all core enables SHALL be 0 outside their owning state.

Reset
REQ-016 rst in any state SHALL return to IDLE next cycle with all outputs 0, o_cycles=0, o_err=0, and all in-flight beats discarded.

Configuration
REQ-017 With QEA_SEQ_TIMEOUT_EN defined, RUN exceeding TIMEOUT_CYCLES cycles without i_qea_complete SHALL go to ERR, set o_err, and pulse o_done; ERR SHALL exit to IDLE on the next i_go, which also clears o_err. Without the macro, RUN waits indefinitely and o_err is tied 0.

Structure
REQ-018 The state enum and ROWS computation function SHALL live in shared package qea_pkg.
REQ-019 The READ path SHALL be a sub-module qea_rd_skid (latency pipe plus one-entry hold register).

Verification
REQ-020 qbit=3, ins=151, PE_NUM=4: 151 ctx writes at addresses 0..150, then 2 state writes, then o_qea_start one cycle, then 2 reads returned in order.
REQ-021 i_ctx_valid toggled every other cycle -> ctx addresses contiguous, no duplicates, o_ctx_en only on valid beats.
REQ-022 i_rd_ready low for 5 cycles on row 0 -> o_rd_data stable, no second read issued until acceptance.
REQ-023 complete asserted 40 cycles after o_qea_start -> o_cycles=41, o_done pulse follows the last row.
REQ-024 With QEA_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, complete never asserted -> ERR at cycle 101 of RUN, o_err=1, o_done pulse.
REQ-025 rst asserted mid LOAD_ST -> IDLE next cycle, all enables 0; a new job with qbit=2, ins=0 completes with 1 state row.
